// File: rtl/eth_reply_tx.sv
// Builds ARP replies and ICMP echo replies as 32-bit words for the MAC TX FIFO.
// First word 1 cycle after IDLE (ARP) or 3 cycles (ping); data/sop/eop held while i_tx_rdy is low.
module eth_reply_tx #(
  parameter int         MIN_WORDS = 16,
  parameter logic [7:0] IP_TTL    = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic        i_arp_req_flag,
  input  logic [47:0] i_arp_req_mac,
  input  logic [31:0] i_arp_req_ip,
  output logic        o_clear_arp_req,
  input  logic        i_ping_req_flag,
  input  logic [47:0] i_ping_req_mac,
  input  logic [31:0] i_ping_req_ip,
  input  logic [7:0]  i_ping_size,
  input  logic [31:0] i_ping_data,
  output logic        o_ping_rdy,
  output logic        o_clear_ping_req,
  output logic [31:0] o_tx_data,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy
);

  typedef enum logic [2:0] {
    IDLE, ARP_TX, PING_PREP, PING_HDR, PING_ICMP, PING_PAY, PAD, DONE
  } state_t;

  localparam logic [8:0] MIN_W    = MIN_WORDS[8:0];
  localparam logic [8:0] ARP_LAST = ((MIN_W > 9'd11) ? MIN_W : 9'd11) - 9'd1;

  state_t      state;
  logic [8:0]  wcnt;
  logic [8:0]  last_idx;
  logic        prep_ph;
  logic        is_arp;
  logic [47:0] dmac;
  logic [47:0] smac;
  logic [31:0] dip;
  logic [31:0] sip;
  logic [7:0]  psize;
  logic [15:0] total_len;
  logic [15:0] ip_id;
  logic [15:0] ip_csum;
  logic [19:0] csum_acc;
  logic        vld;
  logic        sop;
  logic        eop;
  logic        clr_arp;
  logic        clr_ping;

  logic        accept;
  logic [8:0]  wcnt_nx;
  logic [8:0]  ping_words;
  logic [8:0]  ping_last;
  logic [8:0]  pay_last;
  logic [19:0] hdr_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [16:0] icmp_sum;
  logic [15:0] icmp_csum;
  logic [31:0] tx_data;

  assign accept     = vld & i_tx_rdy;
  assign wcnt_nx    = wcnt + 9'd1;
  assign ping_words = 9'd9 + {1'b0, i_ping_size};
  assign ping_last  = ((ping_words > MIN_W) ? ping_words : MIN_W) - 9'd1;
  assign pay_last   = 9'd8 + {1'b0, psize};

  // IPv4 header checksum: wide sum first, then fold the carries back in
  assign hdr_sum = 20'h04500 + {4'd0, total_len} + {4'd0, ip_id} + 20'h04000
                 + {4'd0, IP_TTL, 8'h01}
                 + {4'd0, sip[31:16]} + {4'd0, sip[15:0]}
                 + {4'd0, dip[31:16]} + {4'd0, dip[15:0]};
  assign fold1 = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  // Echo request -> reply changes the type byte 8 -> 0, so the checksum rises by 0x0800
  assign icmp_sum  = {1'b0, i_ping_data[15:0]} + 17'h00800;
  assign icmp_csum = icmp_sum[15:0] + {15'd0, icmp_sum[16]};

  function automatic logic [31:0] mac_word(input logic [1:0]  idx,
                                           input logic [47:0] d,
                                           input logic [47:0] s,
                                           input logic [15:0] etype);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {16'h0000, d[47:32]};
      2'd1:    w = d[31:0];
      2'd2:    w = s[47:16];
      default: w = {s[15:0], etype};
    endcase
    return w;
  endfunction

  always_comb begin
    tx_data = '0;
    case (state)
      ARP_TX: begin
        if (wcnt < 9'd4) begin
          tx_data = mac_word(wcnt[1:0], dmac, smac, 16'h0806);
        end else begin
          case (wcnt[3:0])
            4'd4:    tx_data = 32'h0001_0800;
            4'd5:    tx_data = 32'h0604_0002;
            4'd6:    tx_data = smac[47:16];
            4'd7:    tx_data = {smac[15:0], sip[31:16]};
            4'd8:    tx_data = {sip[15:0], dmac[47:32]};
            4'd9:    tx_data = dmac[31:0];
            4'd10:   tx_data = dip;
            default: tx_data = '0;
          endcase
        end
      end
      PING_HDR: begin
        if (wcnt < 9'd4) begin
          tx_data = mac_word(wcnt[1:0], dmac, smac, 16'h0800);
        end else begin
          case (wcnt[3:0])
            4'd4:    tx_data = {8'h45, 8'h00, total_len};
            4'd5:    tx_data = {ip_id, 16'h4000};
            4'd6:    tx_data = {IP_TTL, 8'h01, ip_csum};
            4'd7:    tx_data = sip;
            4'd8:    tx_data = dip;
            default: tx_data = '0;
          endcase
        end
      end
      PING_ICMP: tx_data = {8'h00, i_ping_data[23:16], icmp_csum};
      PING_PAY:  tx_data = i_ping_data;
      default:   tx_data = '0;
    endcase
  end

  assign o_tx_data        = tx_data;
  assign o_tx_vld         = vld;
  assign o_tx_sop         = sop;
  assign o_tx_eop         = eop;
  assign o_clear_arp_req  = clr_arp;
  assign o_clear_ping_req = clr_ping;
  assign o_ping_rdy       = ((state == PING_ICMP) | (state == PING_PAY)) & i_tx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      last_idx  <= '0;
      prep_ph   <= 1'b0;
      is_arp    <= 1'b0;
      dmac      <= '0;
      smac      <= '0;
      dip       <= '0;
      sip       <= '0;
      psize     <= '0;
      total_len <= '0;
      ip_id     <= '0;
      ip_csum   <= '0;
      csum_acc  <= '0;
      vld       <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      clr_arp   <= 1'b0;
      clr_ping  <= 1'b0;
    end else begin
      clr_arp  <= 1'b0;
      clr_ping <= 1'b0;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (i_arp_req_flag) begin
            is_arp   <= 1'b1;
            dmac     <= i_arp_req_mac;
            dip      <= i_arp_req_ip;
            smac     <= i_self_mac;
            sip      <= i_self_ip;
            last_idx <= ARP_LAST;
            vld      <= 1'b1;
            sop      <= 1'b1;
            eop      <= 1'b0;
            state    <= ARP_TX;
          end else if (i_ping_req_flag) begin
            is_arp    <= 1'b0;
            dmac      <= i_ping_req_mac;
            dip       <= i_ping_req_ip;
            smac      <= i_self_mac;
            sip       <= i_self_ip;
            psize     <= i_ping_size;
            total_len <= 16'd20 + {6'd0, i_ping_size, 2'b00};
            last_idx  <= ping_last;
            prep_ph   <= 1'b0;
            // Without the ICMP header there is nothing to echo: consume the request silently
            if (i_ping_size < 8'd2) begin
              clr_ping <= 1'b1;
              state    <= DONE;
            end else begin
              state <= PING_PREP;
            end
          end
        end
        PING_PREP: begin
          if (!prep_ph) begin
            csum_acc <= hdr_sum;
            prep_ph  <= 1'b1;
          end else begin
            ip_csum <= ~fold2;
            vld     <= 1'b1;
            sop     <= 1'b1;
            eop     <= 1'b0;
            state   <= PING_HDR;
          end
        end
        ARP_TX, PING_HDR, PING_ICMP, PING_PAY, PAD: begin
          if (accept) begin
            if (eop) begin
              vld   <= 1'b0;
              sop   <= 1'b0;
              eop   <= 1'b0;
              state <= DONE;
              if (is_arp) begin
                clr_arp <= 1'b1;
              end else begin
                clr_ping <= 1'b1;
                ip_id    <= ip_id + 16'd1;
              end
            end else begin
              wcnt <= wcnt_nx;
              sop  <= 1'b0;
              eop  <= (wcnt_nx == last_idx);
              case (state)
                ARP_TX:    if (wcnt == 9'd10) state <= PAD;
                PING_HDR:  if (wcnt == 9'd8) state <= PING_ICMP;
                PING_ICMP: state <= PING_PAY;
                PING_PAY:  if (wcnt == pay_last) state <= PAD;
                default:   state <= state;
              endcase
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
